dmem_arbiter: RTL

Two-port arbiter placed in front of the shared data memory. It multiplexes the pipeline MEM stage and a debug/loader port onto the memory's single read/write port. The pipeline has priority by default. An optional starvation guard forces a debug grant after MAX_WAIT blocked cycles and stalls the pipeline for that one cycle. Debug transfers use a req/gnt handshake with a registered response.

---
 rtl/dmem_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the pipeline MEM stage has priority; a debug/loader port uses req/gnt with a registered response.
// Optional starvation guard (forced debug grant after MAX_WAIT blocked cycles) is built when DMEM_ARB_STARVE_GUARD_EN is defined.
module dmem_arbiter #(
  parameter int ADDRESS_LINE = 8,
  parameter int MAX_WAIT     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    p_mem_read,
  input  logic                    p_mem_write,
  input  logic [ADDRESS_LINE-1:0] p_address,
  input  logic [7:0]              p_write_data,
  output logic [7:0]              p_read_data,
  output logic                    p_stall,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDRESS_LINE-1:0] d_address,
  input  logic [7:0]              d_write_data,
  output logic                    d_gnt,
  output logic                    d_valid,
  output logic [7:0]              d_read_data,
  output logic                    m_mem_read,
  output logic                    m_mem_write,
  output logic [ADDRESS_LINE-1:0] m_address,
  output logic [7:0]              m_write_data,
  input  logic [7:0]              m_read_data
);

  logic pipe_req;
  logic forced;
  logic pipe_own;

  assign pipe_req = p_mem_read | p_mem_write;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;

  assign forced = pipe_req & d_req & (wait_cnt == WAIT_LIMIT);

  // Counts cycles the debug port is held off by the pipeline; any grant or dropped request restarts it.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (d_gnt || !d_req) begin
      wait_cnt <= 4'd0;
    end else if (pipe_own && wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  // Reset overrides every request so nothing reaches the memory while the system is held.
  assign d_gnt    = ~reset & d_req & (~pipe_req | forced);
  assign p_stall  = ~reset & forced;
  assign pipe_own = ~reset & pipe_req & ~forced;

  assign p_read_data = m_read_data;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    m_mem_read   = 1'b0;
    m_mem_write  = 1'b0;
    m_address    = '0;
    m_write_data = 8'h00;
    if (d_gnt) begin
      m_mem_read   = ~d_we;
      m_mem_write  = d_we;
      m_address    = d_address;
      m_write_data = d_write_data;
    end else if (pipe_own) begin
      // A simultaneous read+write request resolves to the write.
      m_mem_read   = p_mem_read & ~p_mem_write;
      m_mem_write  = p_mem_write;
      m_address    = p_address;
      m_write_data = p_write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid     <= 1'b0;
      d_read_data <= 8'h00;
    end else begin
      d_valid <= d_gnt;
      if (d_gnt && !d_we) begin
        d_read_data <= m_read_data;
      end
    end
  end

endmodule
